// File: rtl/mesh_pkg.sv
// Shared types and width helpers for the mesh east-boundary result collector.
package mesh_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } collector_state_t;

  localparam int DEFAULT_N          = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // $clog2 clamped to at least one bit so N=1 still yields usable index fields.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mesh_result_collector_if.sv
// Row-major result stream: collector drives data/row/col/valid, consumer drives ready.
interface mesh_result_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 1
);
  logic [DATA_WIDTH-1:0] result_data_o;
  logic [IDX_W-1:0]      result_row_o;
  logic [IDX_W-1:0]      result_col_o;
  logic                  result_valid_o;
  logic                  result_ready_i;

  modport master (
    output result_data_o, result_row_o, result_col_o, result_valid_o,
    input  result_ready_i
  );

  modport slave (
    input  result_data_o, result_row_o, result_col_o, result_valid_o,
    output result_ready_i
  );
endinterface

// File: rtl/mesh_row_capture.sv
// One mesh row's drain capture: word counter and N-word storage filled right to left.
module mesh_row_capture
  import mesh_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  capture_en_i,
  input  logic                  drain_i,
  input  logic [DATA_WIDTH-1:0] east_i,
  output logic [DATA_WIDTH-1:0] words_o [N],
  output logic                  row_full_o,
  output logic                  captured_o
);

  localparam int CNT_W = clog2_min1(N + 1);
  localparam int IDX_W = clog2_min1(N);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      slot_s;
  logic [DATA_WIDTH-1:0] words_q [N];

  // A full row refuses further words; the top flags those as overflow.
  always_comb begin
    row_full_o = (cnt_q == CNT_W'(N));
    captured_o = capture_en_i && drain_i && !row_full_o;
    slot_s     = IDX_W'(N - 1) - IDX_W'(cnt_q);
    if (clear_i) begin
      cnt_d = '0;
    end else if (captured_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      for (int i = 0; i < N; i++) words_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (captured_o) words_q[slot_s] <= east_i;
    end
  end

  assign words_o = words_q;

endmodule

// File: rtl/mesh_result_collector.sv
// East-boundary collector: gathers N*N drained results, then streams them row-major.
module mesh_result_collector
  import mesh_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic [DATA_WIDTH-1:0]  east_i [0:N-1],
  input  logic [N-1:0]           drain_i,
  mesh_result_collector_if.master res_if,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int IDX_W = clog2_min1(N);
  localparam int TOT_W = clog2_min1(N * N + 1);

  collector_state_t      state_q, state_d;
  logic [TOT_W-1:0]      total_q, total_d, cap_count_s;
  logic [IDX_W-1:0]      row_q, row_d, col_q, col_d;
  logic                  err_q, err_d;
  logic [N-1:0]          captured_s, row_full_s;
  logic [DATA_WIDTH-1:0] words_s [N][N];
  logic                  clear_s, collect_s, beat_s, last_beat_s, stray_s, overflow_s;

  for (genvar r = 0; r < N; r++) begin : g_row
    mesh_row_capture #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_row (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .clear_i      (clear_s),
      .capture_en_i (collect_s),
      .drain_i      (drain_i[r]),
      .east_i       (east_i[r]),
      .words_o      (words_s[r]),
      .row_full_o   (row_full_s[r]),
      .captured_o   (captured_s[r])
    );
  end

  // Next-state, counters and sticky error; error set outranks the start-clear.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    row_d       = row_q;
    col_d       = col_q;
    err_d       = err_q;
    cap_count_s = '0;
    for (int r = 0; r < N; r++) cap_count_s = cap_count_s + TOT_W'(captured_s[r]);
    clear_s     = (state_q == IDLE) && start_i;
    collect_s   = (state_q == COLLECT);
    beat_s      = (state_q == STREAM) && res_if.result_ready_i;
    last_beat_s = (row_q == IDX_W'(N - 1)) && (col_q == IDX_W'(N - 1));
    stray_s     = (|drain_i) && !collect_s;
    overflow_s  = collect_s && (|(drain_i & row_full_s));

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COLLECT;
          total_d = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        total_d = total_q + cap_count_s;
        if (total_d == TOT_W'(N * N)) state_d = STREAM;
        else                          state_d = COLLECT;
      end
      STREAM: begin
        if (beat_s && last_beat_s) begin
          state_d = DONE;
          row_d   = '0;
          col_d   = '0;
        end else if (beat_s && (col_q == IDX_W'(N - 1))) begin
          col_d = '0;
          row_d = row_q + IDX_W'(1);
        end else if (beat_s) begin
          col_d = col_q + IDX_W'(1);
        end else begin
          state_d = STREAM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_s) err_d = 1'b0;
    if (stray_s || overflow_s) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      total_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registers; data is forced to zero when no beat is offered.
  always_comb begin
    res_if.result_valid_o = (state_q == STREAM);
    res_if.result_row_o   = row_q;
    res_if.result_col_o   = col_q;
    if (state_q == STREAM) res_if.result_data_o = words_s[row_q][col_q];
    else                   res_if.result_data_o = '0;
    busy_o = (state_q == COLLECT) || (state_q == STREAM);
    done_o = (state_q == DONE);
    err_o  = err_q;
  end

endmodule

// File: doc/mesh_result_collector.md
Name: mesh_result_collector

Overview:
- Sits at the east (drain) boundary of the systolic mesh. It is the receiving end of the mesh's per-row drain interface.
- Captures the accumulated results that each row shifts out eastward while its drain flag is high, and stores them in an N×N result buffer.
- Once all N*N results are captured, streams them out row-major over a valid/ready interface, then pulses done.

Parameters:
- N, 2, mesh dimension; buffer holds N*N words.
- DATA_WIDTH, 32, width of each result word.

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse; arms a new collection and clears err_o.
- east_i  input  [DATA_WIDTH-1:0] x [0:N-1]  per-row result word from the mesh east boundary.
- drain_i  input  [N-1:0]  per-row strobe; bit r high means east_i[r] carries a valid result this cycle.
- result_data_o  output  DATA_WIDTH  streamed result word.
- result_row_o  output  $clog2(N) (min 1)  row index of result_data_o.
- result_col_o  output  $clog2(N) (min 1)  column index of result_data_o.
- result_valid_o  output  1  result beat valid.
- result_ready_i  input  1  downstream accept.
- busy_o  output  1  high in COLLECT or STREAM.
- done_o  output  1  one-cycle pulse after the last beat is accepted.
- err_o  output  1  sticky protocol error flag.

Behaviour:
- Reset values: every output is 0. State is IDLE, all counters are 0, buffer contents are don't-care.
- States:
  - IDLE: start_i -> COLLECT. Clears per-row counters, the total counter and err_o.
  - COLLECT: on each clock edge, every row r with drain_i[r]=1 stores east_i[r] into buf[r][N-1-cnt[r]], then cnt[r]++. Words arrive rightmost column first.
    - Multiple rows may drain in the same cycle; all are captured.
    - The total counter adds popcount(captures this cycle).
    - When total reaches N*N, go to STREAM on the next edge.
  - STREAM: presents buf[0][0] through buf[N-1][N-1] in row-major order.
    - result_valid_o=1 from the first STREAM cycle.
    - The index advances only when valid&&ready.
    - data, row and col are held stable while valid&&!ready.
    - Acceptance of the last beat (N-1,N-1) -> DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency:
  - Last capture edge -> result_valid_o high on the next cycle.
  - Last accept edge -> done_o high on the next cycle.
  - Minimum stream length is N*N cycles with ready held high.
- Boundary conditions:
  - drain_i[r]=1 while cnt[r]==N (row overflow): word dropped, err_o<=1, state unaffected.
  - Any drain_i bit high in IDLE, STREAM or DONE: dropped, err_o<=1.
  - start_i in COLLECT, STREAM or DONE: ignored, no error. A new collection can be armed only from IDLE.
  - start_i and drain_i in the same cycle in IDLE: start wins, drain is flagged as an error. err_o is then set despite the start-clear, because error set takes priority.
  - result_ready_i high while valid=0: no effect.
  - Reset asserted mid-operation: immediate return to IDLE with all outputs 0. Partial buffer contents are discarded.
- Width rules: counters are $clog2(N+1) bits per row and $clog2(N*N+1) bits total. The index is compared, never wrapped.

Decomposition:
- Package mesh_pkg holds:
  - collector_state_t enum {IDLE, COLLECT, STREAM, DONE};
  - localparam helpers for index and count widths (CLOG2 with minimum 1).
- One sub-module, mesh_row_capture (instanced N times):
  - owns one row's cnt[r], its N-word shift/index storage and its overflow detection;
  - exports row_full and captured-this-cycle to the top;
  - the top owns the FSM, the total counter and the stream mux.

Test Plan (N=2, DATA_WIDTH=32):
- Basic drain/stream:
  - Stimulus: start_i; row0 drains 0xA1 then 0xA0; row1 drains 0xB1 then 0xB0 in the same cycles; ready held high.
  - Response: beats (0,0)=0xA0, (0,1)=0xA1, (1,0)=0xB0, (1,1)=0xB1 on consecutive cycles, first beat 1 cycle after the last capture. done_o pulses 1 cycle after beat 4. err_o=0.
- Staggered rows:
  - Stimulus: row0 drains cycles 3–4, row1 drains cycles 6–7.
  - Response: busy_o stays high; STREAM entered only after cycle 7; same row-major ordering.
- Backpressure:
  - Stimulus: ready held low for 3 cycles at beat 2.
  - Response: result_data_o=0xA1, row=0, col=1 held stable; no beats skipped or duplicated; done_o after beat 4.
- Overflow:
  - Stimulus: row0 drains 3 words, 0x1, 0x2, 0x3.
  - Response: err_o=1 from the cycle after the third word; buf row0 = {0x2, 0x1}; the collection still completes once row1 delivers 2 words.
- Stray drain:
  - Stimulus: drain_i=2'b01 in IDLE, then start_i.
  - Response: err_o=1 after the stray drain; cleared by start_i; next collection normal.
- Reset mid-STREAM:
  - Stimulus: rstn_i low after beat 1.
  - Response: all outputs 0 immediately; after release, no valid until a new start_i and a full collection.
